// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-stage access controller sitting between the MEM stage
//             and a word-wide data memory. Accepts one load/store at a time,
//             performs read-modify-write for SB/SH, sign/zero-extends loads,
//             and rejects illegal, misaligned or out-of-range accesses with
//             a fault response that never touches memory.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             req_*_i / req_ready_o  - request handshake, op, address, data
//             resp_*_o / resp_ready_i- response handshake, load data, fault
//             mem_a_o/mem_wd_o/mem_we_o/mem_rd_i - word port to datamem
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int EXT_WIDTH = 32,
   parameter int MEM_WIDTH = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_store_i,
   input  logic [2:0]           req_funct3_i,
   input  logic [EXT_WIDTH-1:0] req_addr_i,
   input  logic [EXT_WIDTH-1:0] req_wdata_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [EXT_WIDTH-1:0] resp_rdata_o,
   output logic                 resp_fault_o,
   output logic [EXT_WIDTH-1:0] mem_a_o,
   output logic [EXT_WIDTH-1:0] mem_wd_o,
   output logic                 mem_we_o,
   input  logic [EXT_WIDTH-1:0] mem_rd_i
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WRITE  = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [EXT_WIDTH-1:0] addr_q;
   logic [EXT_WIDTH-1:0] wdata_q;
   logic [2:0]           funct3_q;
   logic                 store_q;
   logic                 fault_q;
   logic [EXT_WIDTH-1:0] rdata_q;
   logic [EXT_WIDTH-1:0] merge_q;

   logic                 req_legal;
   logic                 req_misaligned;
   logic                 req_out_of_range;
   logic                 req_fault;
   logic                 accept;
   logic [1:0]           lane;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;
   logic [EXT_WIDTH-1:0] load_data;
   logic [EXT_WIDTH-1:0] merge_data;

   // ---------------------------------------------------------------------
   // Request checking on the incoming (not yet latched) request so the
   // fault decision is registered on the acceptance edge.
   // ---------------------------------------------------------------------
   assign accept = req_valid_i && (state_q == S_IDLE);

   always_comb begin
      req_legal = (req_funct3_i == F3_B) || (req_funct3_i == F3_H) ||
                  (req_funct3_i == F3_W) ||
                  (!req_store_i && ((req_funct3_i == F3_BU) ||
                                    (req_funct3_i == F3_HU)));
      // funct3[1:0]==01 covers both H and HU.
      req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00));
      req_out_of_range = |req_addr_i[EXT_WIDTH-1:MEM_WIDTH];
      req_fault = !req_legal || req_misaligned || req_out_of_range;
   end

   // ---------------------------------------------------------------------
   // Load lane extraction and extension
   // ---------------------------------------------------------------------
   assign lane = addr_q[1:0];

   always_comb begin
      rd_byte = 8'h00;
      case (lane)
         2'd0:    rd_byte = mem_rd_i[7:0];
         2'd1:    rd_byte = mem_rd_i[15:8];
         2'd2:    rd_byte = mem_rd_i[23:16];
         default: rd_byte = mem_rd_i[31:24];
      endcase
      rd_half = lane[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

      load_data = mem_rd_i;
      case (funct3_q)
         F3_B:    load_data = {{(EXT_WIDTH-8){rd_byte[7]}}, rd_byte};
         F3_H:    load_data = {{(EXT_WIDTH-16){rd_half[15]}}, rd_half};
         F3_BU:   load_data = {{(EXT_WIDTH-8){1'b0}}, rd_byte};
         F3_HU:   load_data = {{(EXT_WIDTH-16){1'b0}}, rd_half};
         default: load_data = mem_rd_i;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sub-word store merge into the current memory word
   // ---------------------------------------------------------------------
   always_comb begin
      merge_data = mem_rd_i;
      if (funct3_q == F3_H) begin
         if (lane[1]) merge_data[31:16] = wdata_q[15:0];
         else         merge_data[15:0]  = wdata_q[15:0];
      end else begin
         case (lane)
            2'd0:    merge_data[7:0]   = wdata_q[7:0];
            2'd1:    merge_data[15:8]  = wdata_q[7:0];
            2'd2:    merge_data[23:16] = wdata_q[7:0];
            default: merge_data[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) state_d = req_fault ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            // Only sub-word stores need the extra write cycle.
            state_d = (store_q && (funct3_q != F3_W)) ? S_WRITE : S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         default: begin
            if (resp_ready_i) state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         store_q  <= 1'b0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
         merge_q  <= '0;
      end else if (accept) begin
         addr_q   <= req_addr_i;
         wdata_q  <= req_wdata_i;
         funct3_q <= req_funct3_i;
         store_q  <= req_store_i;
         fault_q  <= req_fault;
         rdata_q  <= '0;
      end else if (state_q == S_ACCESS) begin
         if (store_q) merge_q <= merge_data;
         else         rdata_q <= load_data;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs. rst_n gating keeps req_ready/mem_we at 0 during reset even
   // though the state register itself sits in IDLE.
   // ---------------------------------------------------------------------
   assign req_ready_o  = rst_n && (state_q == S_IDLE);
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_fault_o = fault_q;
   assign mem_a_o      = {addr_q[EXT_WIDTH-1:2], 2'b00};
   assign mem_wd_o     = (state_q == S_WRITE) ? merge_q : wdata_q;
   assign mem_we_o     = rst_n &&
                         ((state_q == S_WRITE) ||
                          ((state_q == S_ACCESS) && store_q && (funct3_q == F3_W)));

endmodule
`default_nettype wire
